// File: rtl/k2red_mul_feeder_if.sv
// A/Q/l job bundle for the K2-RED operand feeder: job intake on one handshake,
// product plus pass-through modulus/shift terms on the other.
interface k2red_mul_feeder_if #(
    parameter int W     = 32,
    parameter int LOG_L = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     X;
    logic [W-1:0]     Y;
    logic [W-1:0]     Q;
    logic [LOG_L-1:0] l1;
    logic [LOG_L-1:0] l2;
    logic [LOG_L-1:0] l3;

    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   A;
    logic [W-1:0]     Q_o;
    logic [LOG_L-1:0] l1_o;
    logic [LOG_L-1:0] l2_o;
    logic [LOG_L-1:0] l3_o;

    // Job source / result sink side.
    modport master (
        output in_valid, X, Y, Q, l1, l2, l3, out_ready,
        input  in_ready, out_valid, A, Q_o, l1_o, l2_o, l3_o
    );

    // Feeder side.
    modport slave (
        input  in_valid, X, Y, Q, l1, l2, l3, out_ready,
        output in_ready, out_valid, A, Q_o, l1_o, l2_o, l3_o
    );
endinterface

// File: rtl/k2red_mul_feeder.sv
// Sequential operand producer for the K2-RED reducer: reduces X and Y once below Q,
// multiplies them with a radix-2 shift-add loop and hands A/Q/l downstream.
module k2red_mul_feeder #(
    parameter int W     = 32,
    parameter int LOG_L = 4
) (
    input  logic               clk,
    input  logic               rst,
    k2red_mul_feeder_if.slave  bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_MUL,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [W-1:0]     r_x;
    logic [W-1:0]     r_y;
    logic [W-1:0]     r_q;
    logic [LOG_L-1:0] r_l1;
    logic [LOG_L-1:0] r_l2;
    logic [LOG_L-1:0] r_l3;
    logic [2*W-1:0]   r_mcand;
    logic [W-1:0]     r_mplier;
    logic [2*W-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;

    logic [W-1:0]     w_x_red;
    logic [W-1:0]     w_y_red;
    logic [2*W-1:0]   w_acc_next;

    // Q > 2^(W-1) guarantees a single conditional subtraction lands below Q.
    assign w_x_red = (r_x >= r_q) ? (r_x - r_q) : r_x;
    assign w_y_red = (r_y >= r_q) ? (r_y - r_q) : r_y;

    // Multiplier shifts right so its LSB is always the current bit Y'[i];
    // the multiplicand shifts left so it always holds X'*2^i.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_q         <= '0;
            r_l1        <= '0;
            r_l2        <= '0;
            r_l3        <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_x        <= bus.X;
                        r_y        <= bus.Y;
                        r_q        <= bus.Q;
                        r_l1       <= bus.l1;
                        r_l2       <= bus.l2;
                        r_l3       <= bus.l3;
                        r_in_ready <= 1'b0;
                        r_state    <= S_PREP;
                    end
                end

                S_PREP: begin
                    r_mcand  <= {{W{1'b0}}, w_x_red};
                    r_mplier <= w_y_red;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_state  <= S_MUL;
                end

                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.A         = r_acc;
    assign bus.Q_o       = r_q;
    assign bus.l1_o      = r_l1;
    assign bus.l2_o      = r_l2;
    assign bus.l3_o      = r_l3;
endmodule

// File: tb/tb_k2red_mul_feeder.sv
// Directed bench for k2red_mul_feeder: reset, products, reduction, backpressure,
// back-to-back jobs and reset abort.
module tb_k2red_mul_feeder;
    localparam int W     = 32;
    localparam int LOG_L = 4;
    localparam logic [31:0] QM = 32'd2148794369;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    k2red_mul_feeder_if #(.W(W), .LOG_L(LOG_L)) bus ();

    k2red_mul_feeder #(.W(W), .LOG_L(LOG_L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Submits one job and waits for out_valid; out_ready is left to the caller.
    task automatic run_job(input logic [31:0] x, input logic [31:0] y,
                           input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                           output logic [63:0] a, output logic [31:0] qo,
                           output logic [3:0] o1, output logic [3:0] o2, output logic [3:0] o3,
                           output int lat, output bit tmo);
        int n;
        a = '0; qo = '0; o1 = '0; o2 = '0; o3 = '0;
        tmo = 1'b0; lat = 0; n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) begin tmo = 1'b1; return; end
        bus.X = x; bus.Y = y; bus.Q = QM;
        bus.l1 = a1; bus.l2 = a2; bus.l3 = a3;
        bus.in_valid = 1'b1;
        tick();
        lat = 1;
        bus.in_valid = 1'b0;
        // Scramble inputs after acceptance; they must have no effect.
        bus.X = ~x; bus.Y = ~y; bus.Q = 32'h8000_0001; bus.l1 = ~a1; bus.l2 = ~a2; bus.l3 = ~a3;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin tick(); lat++; n++; end
        if (n >= 200) tmo = 1'b1;
        a = bus.A; qo = bus.Q_o; o1 = bus.l1_o; o2 = bus.l2_o; o3 = bus.l3_o;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.X = '0; bus.Y = '0; bus.Q = QM; bus.l1 = '0; bus.l2 = '0; bus.l3 = '0;
        rst = 1'b0;
        tick(); tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.A !== 64'd0) begin bad++; $display("FAIL reset_A got=%0d exp=0", bus.A); end
        total++; if (bus.Q_o !== 32'd0) begin bad++; $display("FAIL reset_Q_o got=%0d exp=0", bus.Q_o); end
        total++; if ({bus.l1_o, bus.l2_o, bus.l3_o} !== 12'd0) begin bad++; $display("FAIL reset_l got=%h exp=000", {bus.l1_o, bus.l2_o, bus.l3_o}); end
        rst = 1'b1;
        tick();
        $display("reset: in_ready=%b out_valid=%b A=%0d", bus.in_ready, bus.out_valid, bus.A);
    endtask

    task automatic test_basic();
        logic [63:0] a; logic [31:0] qo; logic [3:0] o1, o2, o3; int lat; bit tmo;
        bus.out_ready = 1'b1;
        run_job(32'd3, 32'd5, 4'd2, 4'd1, 4'd3, a, qo, o1, o2, o3, lat, tmo);
        $display("basic: 3*5 A=%0d lat=%0d", a, lat);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b exp=0", tmo); end
        total++; if (lat != 34) begin bad++; $display("FAIL basic_latency got=%0d exp=34", lat); end
        total++; if (a !== 64'd15) begin bad++; $display("FAIL basic_A got=%0d exp=15", a); end
        total++; if (qo !== QM) begin bad++; $display("FAIL basic_Q_o got=%0d exp=%0d", qo, QM); end
        total++; if ({o1, o2, o3} !== {4'd2, 4'd1, 4'd3}) begin bad++; $display("FAIL basic_l got=%0d,%0d,%0d exp=2,1,3", o1, o2, o3); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_out_valid_drop got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_rise got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_reduction();
        logic [63:0] a; logic [31:0] qo; logic [3:0] o1, o2, o3; int lat; bit tmo;
        bus.out_ready = 1'b1;
        run_job(QM + 32'd1, 32'd7, 4'd4, 4'd5, 4'd6, a, qo, o1, o2, o3, lat, tmo);
        $display("reduction: (Q+1)*7 A=%0d", a);
        total++; if (tmo !== 1'b0 || a !== 64'd7) begin bad++; $display("FAIL reduce_x got=%0d exp=7 tmo=%b", a, tmo); end
        tick();
        run_job(32'd10, QM + 32'd3, 4'd0, 4'd15, 4'd8, a, qo, o1, o2, o3, lat, tmo);
        $display("reduction: 10*(Q+3) A=%0d", a);
        total++; if (tmo !== 1'b0 || a !== 64'd30) begin bad++; $display("FAIL reduce_y got=%0d exp=30 tmo=%b", a, tmo); end
        total++; if ({o1, o2, o3} !== {4'd0, 4'd15, 4'd8}) begin bad++; $display("FAIL reduce_l got=%0d,%0d,%0d exp=0,15,8", o1, o2, o3); end
        tick();
        run_job(QM, 32'd12345, 4'd1, 4'd1, 4'd1, a, qo, o1, o2, o3, lat, tmo);
        $display("reduction: Q*12345 A=%0d", a);
        total++; if (tmo !== 1'b0 || a !== 64'd0) begin bad++; $display("FAIL reduce_eq_q got=%0d exp=0 tmo=%b", a, tmo); end
        tick();
    endtask

    task automatic test_max();
        logic [63:0] a; logic [31:0] qo; logic [3:0] o1, o2, o3; int lat; bit tmo;
        bus.out_ready = 1'b1;
        run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 4'd7, 4'd7, a, qo, o1, o2, o3, lat, tmo);
        $display("max: A=%0d", a);
        total++; if (tmo !== 1'b0 || a !== 64'd4606058228295401476) begin bad++; $display("FAIL max_A got=%0d exp=4606058228295401476 tmo=%b", a, tmo); end
        tick();
        run_job(32'd0, 32'hFFFF_FFFF, 4'd2, 4'd2, 4'd2, a, qo, o1, o2, o3, lat, tmo);
        $display("max: 0*max A=%0d lat=%0d", a, lat);
        total++; if (a !== 64'd0 || lat != 34) begin bad++; $display("FAIL zero_x got A=%0d lat=%0d exp A=0 lat=34", a, lat); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [63:0] a; logic [31:0] qo; logic [3:0] o1, o2, o3; int lat; bit tmo;
        int held_bad, stray;
        bus.out_ready = 1'b0;
        run_job(32'd6, 32'd7, 4'd5, 4'd9, 4'd15, a, qo, o1, o2, o3, lat, tmo);
        total++; if (tmo !== 1'b0 || a !== 64'd42) begin bad++; $display("FAIL bp_A got=%0d exp=42 tmo=%b", a, tmo); end
        held_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin bus.X = 32'd1; bus.Y = 32'd1; bus.in_valid = 1'b1; end
            tick();
            bus.in_valid = 1'b0;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.A !== 64'd42 || bus.Q_o !== QM ||
                {bus.l1_o, bus.l2_o, bus.l3_o} !== {4'd5, 4'd9, 4'd15}) held_bad++;
        end
        $display("backpressure: held 10 cycles, unstable cycles=%0d", held_bad);
        total++; if (held_bad != 0) begin bad++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", held_bad); end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) stray++;
        end
        $display("backpressure: stray activity after release=%0d", stray);
        total++; if (stray != 0) begin bad++; $display("FAIL bp_ignored_pulse got=%0d stray cycles exp=0", stray); end
    endtask

    task automatic test_back_to_back();
        int n, lat;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin tick(); n++; end
        bus.X = 32'd3; bus.Y = 32'd5; bus.Q = QM; bus.l1 = 4'd1; bus.l2 = 4'd2; bus.l3 = 4'd3;
        bus.in_valid = 1'b1;
        tick();
        bus.X = 32'd0; bus.Y = 32'd9;
        lat = 1; n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin tick(); lat++; n++; end
        $display("b2b: job1 A=%0d lat=%0d", bus.A, lat);
        total++; if (bus.A !== 64'd15 || lat != 34) begin bad++; $display("FAIL b2b_job1 got A=%0d lat=%0d exp A=15 lat=34", bus.A, lat); end
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_transfer got valid=%b ready=%b exp 0,1", bus.out_valid, bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept2 got in_ready=%b exp=0", bus.in_ready); end
        lat = 1; n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin tick(); lat++; n++; end
        $display("b2b: job2 A=%0d lat=%0d", bus.A, lat);
        total++; if (bus.A !== 64'd0 || lat != 34) begin bad++; $display("FAIL b2b_job2 got A=%0d lat=%0d exp A=0 lat=34", bus.A, lat); end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        logic [63:0] a; logic [31:0] qo; logic [3:0] o1, o2, o3; int lat, n, stray; bit tmo;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin tick(); n++; end
        bus.X = 32'd3; bus.Y = 32'd5; bus.Q = QM; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.A !== 64'd0) begin bad++; $display("FAIL abort_outputs got valid=%b A=%0d exp 0,0", bus.out_valid, bus.A); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid === 1'b1) stray++;
        end
        $display("reset_mid_mul: stale outputs after abort=%0d", stray);
        total++; if (stray != 0) begin bad++; $display("FAIL abort_stale got=%0d exp=0", stray); end
        run_job(32'd3, 32'd5, 4'd2, 4'd1, 4'd3, a, qo, o1, o2, o3, lat, tmo);
        $display("reset_mid_mul: next job A=%0d lat=%0d", a, lat);
        total++; if (tmo !== 1'b0 || a !== 64'd15 || lat != 34) begin bad++; $display("FAIL abort_next_job got A=%0d lat=%0d exp A=15 lat=34", a, lat); end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_reduction();
        test_max();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
